// File: rtl/obstacle_pkg.sv
// Types and encodings shared by the obstacle bitmap, hit-controller and video-mux stages.
package obstacle_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_FLASH,
    ST_DEAD
  } obst_state_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  // Increment that sticks at limit instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/obstacle_hit_controller_frame_countdown.sv
// Frame-rate down counter: loadable, steps once per startOfFrame while running,
// and flags when the value it is about to hold is zero.
module frame_countdown (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sof,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] count_q, count_d;

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (sof && run) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_d == 8'd0);

  // The owning FSM leaves the running state on the step that reaches zero.
  no_underflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(sof && run && !load && count_q == 8'd0));

endmodule

// File: rtl/obstacle_hit_controller.sv
// Per-obstacle hit tracking: frame-wise missile/ship overlap detection, health FSM
// (ALIVE -> FLASH -> DEAD -> respawn) and registered gating of the obstacle's pixels.
module obstacle_hit_controller
  import obstacle_pkg::*;
#(
  parameter int unsigned HITS_TO_DESTROY = 3,
  parameter int unsigned FLASH_FRAMES    = 16,
  parameter int unsigned BLINK_SHIFT     = 1,
  parameter int unsigned RESPAWN_FRAMES  = 90,
  parameter logic [7:0]  FLASH_COLOR     = 8'hE0
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       obstacleDR,
  input  logic [7:0] obstacleRGB,
  input  logic       missileDR,
  input  logic       shipDR,
  output logic       drawingRequest,
  output logic [7:0] RGBout,
  output logic       missileHit,
  output logic       obstacleDestroyed,
  output logic       shipCollision,
  output logic       obstacleAlive,
  output logic [3:0] hitCount
);

  localparam logic [3:0] HITS_MAX     = 4'(HITS_TO_DESTROY);
  localparam logic [7:0] FLASH_LOAD   = 8'(FLASH_FRAMES);
  localparam logic [7:0] RESPAWN_LOAD = 8'(RESPAWN_FRAMES);

  obst_state_t state_q, state_d;
  logic [3:0]  hit_count_q, hit_count_d, next_hits;
  logic        m_seen_q, m_seen_d, s_seen_q, s_seen_d;
  logic        missile_hit_q, missile_hit_d;
  logic        destroyed_q, destroyed_d;
  logic        ship_coll_q, ship_coll_d;
  logic        draw_q, draw_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        visible, draw_en, m_eval, s_eval;
  logic        flash_load, resp_load, flash_zero, resp_zero;
  logic [7:0]  flash_cnt, resp_cnt;
  logic        cnt_unused;

  frame_countdown u_flash_timer (
    .clk        (clk),
    .rst_n      (resetN),
    .sof        (startOfFrame),
    .run        (state_q == ST_FLASH),
    .load       (flash_load),
    .load_value (FLASH_LOAD),
    .count      (flash_cnt),
    .zero       (flash_zero)
  );

  frame_countdown u_respawn_timer (
    .clk        (clk),
    .rst_n      (resetN),
    .sof        (startOfFrame),
    .run        (state_q == ST_DEAD),
    .load       (resp_load),
    .load_value (RESPAWN_LOAD),
    .count      (resp_cnt),
    .zero       (resp_zero)
  );

  assign cnt_unused = ^{flash_cnt, resp_cnt};

  always_comb begin
    state_d       = state_q;
    hit_count_d   = hit_count_q;
    m_seen_d      = m_seen_q;
    s_seen_d      = s_seen_q;
    missile_hit_d = 1'b0;
    destroyed_d   = 1'b0;
    ship_coll_d   = 1'b0;
    flash_load    = 1'b0;
    resp_load     = 1'b0;
    next_hits     = sat_inc(hit_count_q, HITS_MAX);

    visible = (state_q == ST_ALIVE) || (state_q == ST_FLASH && !flash_cnt[BLINK_SHIFT]);
    draw_en = obstacleDR && visible;
    // The startOfFrame cycle's own overlap still belongs to the frame that is ending.
    m_eval  = m_seen_q || (draw_en && missileDR);
    s_eval  = s_seen_q || (draw_en && shipDR);

    draw_d = draw_en;
    rgb_d  = !draw_en ? TRANSPARENT_ENCODING
           : (state_q == ST_FLASH) ? FLASH_COLOR : obstacleRGB;

    if (!startOfFrame) begin
      m_seen_d = m_eval;
      s_seen_d = s_eval;
    end else begin
      m_seen_d    = 1'b0;
      s_seen_d    = 1'b0;
      ship_coll_d = s_eval && (state_q != ST_DEAD);
      unique case (state_q)
        ST_ALIVE: begin
          if (m_eval) begin
            hit_count_d   = next_hits;
            missile_hit_d = 1'b1;
            if (next_hits == HITS_MAX) begin
              state_d     = ST_DEAD;
              destroyed_d = 1'b1;
              resp_load   = 1'b1;
            end else begin
              state_d    = ST_FLASH;
              flash_load = 1'b1;
            end
          end
        end
        ST_FLASH: begin
          if (flash_zero) state_d = ST_ALIVE;
        end
        ST_DEAD: begin
          if (resp_zero) begin
            state_d     = ST_ALIVE;
            hit_count_d = 4'd0;
          end
        end
        default: state_d = ST_ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_ALIVE;
      hit_count_q   <= 4'd0;
      m_seen_q      <= 1'b0;
      s_seen_q      <= 1'b0;
      missile_hit_q <= 1'b0;
      destroyed_q   <= 1'b0;
      ship_coll_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hit_count_q   <= hit_count_d;
      m_seen_q      <= m_seen_d;
      s_seen_q      <= s_seen_d;
      missile_hit_q <= missile_hit_d;
      destroyed_q   <= destroyed_d;
      ship_coll_q   <= ship_coll_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_q <= 1'b0;
      rgb_q  <= TRANSPARENT_ENCODING;
    end else begin
      draw_q <= draw_d;
      rgb_q  <= rgb_d;
    end
  end

  assign drawingRequest    = draw_q;
  assign RGBout            = rgb_q;
  assign missileHit        = missile_hit_q;
  assign obstacleDestroyed = destroyed_q;
  assign shipCollision     = ship_coll_q;
  assign obstacleAlive     = (state_q != ST_DEAD);
  assign hitCount          = hit_count_q;

endmodule

// File: tb/tb_obstacle_hit_controller.sv
// Directed bench for obstacle_hit_controller: stimulus pushes expected pulse events into a
// scoreboard queue, an independent monitor pops and compares whenever a pulse appears.
module tb_obstacle_hit_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, obstacleDR, missileDR, shipDR;
  logic [7:0] obstacleRGB;
  logic       drawingRequest, missileHit, obstacleDestroyed, shipCollision, obstacleAlive;
  logic [7:0] RGBout;
  logic [3:0] hitCount;

  typedef struct packed {
    logic       m;
    logic       d;
    logic       s;
    logic [3:0] hits;
    logic       alive;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fails  = 0;

  obstacle_hit_controller dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .obstacleDR        (obstacleDR),
    .obstacleRGB       (obstacleRGB),
    .missileDR         (missileDR),
    .shipDR            (shipDR),
    .drawingRequest    (drawingRequest),
    .RGBout            (RGBout),
    .missileHit        (missileHit),
    .obstacleDestroyed (obstacleDestroyed),
    .shipCollision     (shipCollision),
    .obstacleAlive     (obstacleAlive),
    .hitCount          (hitCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic m, input logic d, input logic s,
                              input logic [3:0] hits, input logic alive);
    exp_t e;
    e.m = m; e.d = d; e.s = s; e.hits = hits; e.alive = alive;
    return e;
  endfunction

  // Inputs change on the falling edge; they are sampled by the next rising edge.
  task automatic step(input logic sof, input logic dr, input logic [7:0] rgb,
                      input logic m, input logic s);
    @(negedge clk);
    startOfFrame = sof;
    obstacleDR   = dr;
    obstacleRGB  = rgb;
    missileDR    = m;
    shipDR       = s;
  endtask

  task automatic hold();
    @(negedge clk);
  endtask

  task automatic check_gate(input string name, input logic dr, input logic [7:0] rgb);
    check({name, "_dr"},  16'(drawingRequest), 16'(dr));
    check({name, "_rgb"}, 16'(RGBout),         16'(rgb));
  endtask

  task automatic idle_frame();
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) idle_frame();
  endtask

  // Monitor: every pulse the DUT presents must match the oldest expected event.
  always @(negedge clk) begin
    if (missileHit || obstacleDestroyed || shipCollision) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_pulse: got m=%0b d=%0b s=%0b hits=%0d, expected no pulse (t=%0t)",
                 missileHit, obstacleDestroyed, shipCollision, hitCount, $time);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_event",
              16'({missileHit, obstacleDestroyed, shipCollision, hitCount, obstacleAlive}),
              16'(mon_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic vis_tbl [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0; obstacleDR = 1'b0; obstacleRGB = 8'hFF; missileDR = 1'b0; shipDR = 1'b0;
    repeat (3) @(negedge clk);
    check_gate("reset", 1'b0, 8'hFF);
    check("reset_pulses", 16'({missileHit, obstacleDestroyed, shipCollision}), 16'd0);
    check("reset_alive",  16'(obstacleAlive), 16'd1);
    check("reset_hits",   16'(hitCount), 16'd0);
    resetN = 1'b1;

    // 1: plain drawing passes through with one clock of latency.
    step(1'b0, 1'b1, 8'h5B, 1'b0, 1'b0);
    check_gate("t1_latency", 1'b0, 8'hFF);
    hold();
    check_gate("t1_clk2", 1'b1, 8'h5B);
    repeat (8) hold();
    check_gate("t1_clk10", 1'b1, 8'h5B);
    check("t1_hits", 16'(hitCount), 16'd0);

    // 2: single missile pixel, then SOF -> hit 1, FLASH with blink pattern from flashCnt bit 1.
    step(1'b0, 1'b1, 8'h5B, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 1'b1));
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);

    // 4 folded in: missile ignored in FLASH, ship only counts on visible frames.
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 8'h5B, (k == 0 || k == 3), (k == 1 || k == 3));
      hold();
      check_gate($sformatf("flash_f%0d", k), vis_tbl[k], vis_tbl[k] ? 8'hE0 : 8'hFF);
      step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
      if (k == 3) sb.push_back(mk(1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
      step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 8'h5B, 1'b0, 1'b0);
    hold();
    check_gate("after_flash", 1'b1, 8'h5B);
    check("after_flash_hits", 16'(hitCount), 16'd1);

    // 3: second and third hits; third destroys, respawn after 90 frames.
    step(1'b0, 1'b1, 8'h5B, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 4'd2, 1'b1));
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    frames(16);
    step(1'b0, 1'b1, 8'h5B, 1'b1, 1'b0);
    check("hit2_hits", 16'(hitCount), 16'd2);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 1'b1, 1'b0, 4'd3, 1'b0));
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);

    // 6 (second half): DEAD hides the obstacle and ignores ship overlap.
    step(1'b0, 1'b1, 8'h5B, 1'b1, 1'b1);
    hold();
    check_gate("dead", 1'b0, 8'hFF);
    check("dead_alive", 16'(obstacleAlive), 16'd0);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    frames(88);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    check("dead_after_89", 16'(obstacleAlive), 16'd0);
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    check("respawn_alive", 16'(obstacleAlive), 16'd1);
    check("respawn_hits",  16'(hitCount), 16'd0);

    // 5: overlap on the SOF cycle itself counts for the ending frame.
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 1'b1));
    step(1'b1, 1'b1, 8'h5B, 1'b1, 1'b0);
    frames(16);
    // Missile and ship in one frame -> both pulses together.
    step(1'b0, 1'b1, 8'h5B, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 1'b0, 1'b1, 4'd2, 1'b1));
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);

    // 6: async reset mid-FLASH at flashCnt=7.
    frames(8);
    step(1'b0, 1'b1, 8'h5B, 1'b0, 1'b0);
    hold();
    check_gate("flash_cnt8", 1'b1, 8'hE0);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h5B, 1'b1, 1'b1);
    #2 resetN = 1'b0;
    #1;
    check_gate("async_reset", 1'b0, 8'hFF);
    check("async_reset_alive", 16'(obstacleAlive), 16'd1);
    check("async_reset_hits",  16'(hitCount), 16'd0);
    step(1'b1, 1'b1, 8'h5B, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    check("sof_in_reset_hits", 16'(hitCount), 16'd0);
    @(negedge clk);
    resetN = 1'b1;
    step(1'b0, 1'b1, 8'h5B, 1'b0, 1'b0);
    hold();
    check_gate("post_reset_alive", 1'b1, 8'h5B);
    idle_frame();
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    hold();
    check("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
